// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port register file with write-to-read
// bypass and a per-register busy scoreboard for pipeline interlock.
//
// Parameters: DATA_W (data width), ADDR_W (depth = 2**ADDR_W), NRD (read
// ports, 1..4), ZERO_REG (1 = register 0 is hardwired zero, never busy).
//
// Ports:
//   clk, clr               clock, synchronous active-high reset
//   rd_addr/rd_data/rd_busy packed read ports, port i at slice i
//   we0/wn0/d0             write port 0
//   we1/wn1/d1             write port 1 (wins on same-address collision)
//   iss_en/iss_wn          issue: mark destination register busy
//   wconflict              sticky same-address dual-write flag, only when
//                          REGFILE_WCONFLICT_EN is defined
//
// Optional feature macro: REGFILE_WCONFLICT_EN.

// Per-read-port resolution: bypass priority, busy override, zero register.
module regfile_mp_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              arr_busy,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wn0,
  input  logic [DATA_W-1:0] d0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wn1,
  input  logic [DATA_W-1:0] d1,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_wn,
  output logic [DATA_W-1:0] data,
  output logic              busy
);
  // Enables arriving here are already qualified by clr and the zero register,
  // so bypass switches off by itself during reset.
  logic hit0, hit1, hit_iss, zero;

  assign hit0    = we0 && (wn0 == addr);
  assign hit1    = we1 && (wn1 == addr);
  assign hit_iss = iss_en && (iss_wn == addr);
  assign zero    = (ZERO_REG != 0) && (addr == '0);

  always_comb begin
    data = arr_data;
    busy = arr_busy;
    if (hit1)      data = d1;
    else if (hit0) data = d0;
    // Bypassed data is valid unless a new producer claims the register now.
    if ((hit0 || hit1) && !hit_iss) busy = 1'b0;
    if (clr) busy = 1'b0;
    if (zero) begin
      data = '0;
      busy = 1'b0;
    end
  end
endmodule

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wn0,
  input  logic [DATA_W-1:0]     d0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wn1,
  input  logic [DATA_W-1:0]     d1,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_wn
`ifdef REGFILE_WCONFLICT_EN
  , output logic                wconflict
`endif
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy;

  // Qualified enables: nothing takes effect under clr or targets the zero reg.
  logic we0_e, we1_e, iss_e;
  assign we0_e = we0 && !clr && !((ZERO_REG != 0) && (wn0 == '0));
  assign we1_e = we1 && !clr && !((ZERO_REG != 0) && (wn1 == '0));
  assign iss_e = iss_en && !clr && !((ZERO_REG != 0) && (iss_wn == '0));

  always_ff @(posedge clk) begin
    if (clr) begin
      regs <= '0;
      busy <= '0;
    end else begin
      // Port 1 is assigned last so it wins a same-address collision.
      if (we0_e) regs[wn0] <= d0;
      if (we1_e) regs[wn1] <= d1;
      for (int r = 0; r < DEPTH; r++) begin
        if (iss_e && (iss_wn == ADDR_W'(r)))
          busy[r] <= 1'b1;
        else if ((we0_e && (wn0 == ADDR_W'(r))) || (we1_e && (wn1 == ADDR_W'(r))))
          busy[r] <= 1'b0;
      end
    end
  end

`ifdef REGFILE_WCONFLICT_EN
  always_ff @(posedge clk) begin
    if (clr)
      wconflict <= 1'b0;
    else if (we0 && we1 && (wn0 == wn1) && !((ZERO_REG != 0) && (wn0 == '0)))
      wconflict <= 1'b1;
  end
`endif

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_mp_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .clr      (clr),
      .addr     (addr),
      .arr_data (regs[addr]),
      .arr_busy (busy[addr]),
      .we0      (we0_e),
      .wn0      (wn0),
      .d0       (d0),
      .we1      (we1_e),
      .wn1      (wn1),
      .d1       (d1),
      .iss_en   (iss_e),
      .iss_wn   (iss_wn),
      .data     (rd_data[i*DATA_W +: DATA_W]),
      .busy     (rd_busy[i])
    );
  end
endmodule
